// File: rtl/core_ctrl_pkg.sv
// Shared types for the core run/halt sequencer: FSM states and halt causes.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_REQ     = 3'd1,
        CAUSE_BREAK   = 3'd2,
        CAUSE_STEP    = 3'd3,
        CAUSE_ILLEGAL = 3'd4,
        CAUSE_BOOT    = 3'd5
    } halt_cause_t;

    localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/ctrl_counter.sv
// Free-running wrap-around counter with synchronous clear taking priority over increment.
module ctrl_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_inc) begin
            o_cnt <= o_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/single-step sequencer for the RV32I core: gates commits through o_core_en,
// halts on request, PC breakpoint or illegal instruction, and counts cycles/instructions.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_HOLD = 4,
    parameter bit          AUTORUN   = 1'b1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run_req,
    input  logic             i_halt_req,
    input  logic             i_step_req,
    input  logic             i_bp_en,
    input  logic [31:0]      i_bp_addr,
    input  logic [31:0]      i_pc,
    input  logic             i_insn_vld,
    input  logic             i_cnt_clr,
    output logic             o_core_en,
    output logic             o_halted,
    output logic [1:0]       o_state,
    output logic [2:0]       o_halt_cause,
    output logic             o_step_done,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_insn_cnt
);

    run_state_t        state, state_nxt;
    halt_cause_t       cause, cause_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              resume_mask, mask_nxt;
    logic              step_done;
    logic              pc_match;
    logic              bp_hit;
    logic              in_run;
    logic              in_step;

    assign in_run   = (state == ST_RUN);
    assign in_step  = (state == ST_STEP);
    assign pc_match = (i_pc == i_bp_addr);
    assign bp_hit   = i_bp_en & pc_match & ~resume_mask;

    // A blocked instruction never commits, so the PC register holds its value.
    assign o_core_en = (in_run | in_step) & i_insn_vld & ~bp_hit & ~(in_run & i_halt_req);

    assign o_halted     = (state == ST_HALTED);
    assign o_state      = state;
    assign o_halt_cause = cause;
    assign o_step_done  = step_done;

    // Next-state, halt cause, boot hold and breakpoint resume mask.
    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        hold_nxt  = hold_cnt;
        mask_nxt  = resume_mask & ~o_core_en;
        case (state)
            ST_BOOT: begin
                if (hold_cnt == HOLD_W'(BOOT_HOLD - 1)) begin
                    hold_nxt = '0;
                    if (AUTORUN) begin
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_HALTED;
                        cause_nxt = CAUSE_BOOT;
                    end
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (i_halt_req) begin
                    state_nxt = ST_HALTED;
                    cause_nxt = CAUSE_REQ;
                end else if (bp_hit) begin
                    state_nxt = ST_HALTED;
                    cause_nxt = CAUSE_BREAK;
                end else if (!i_insn_vld) begin
                    state_nxt = ST_HALTED;
                    cause_nxt = CAUSE_ILLEGAL;
                end
            end
            ST_STEP: begin
                state_nxt = ST_HALTED;
                if (bp_hit) begin
                    cause_nxt = CAUSE_BREAK;
                end else if (!i_insn_vld) begin
                    cause_nxt = CAUSE_ILLEGAL;
                end else begin
                    cause_nxt = CAUSE_STEP;
                end
            end
            ST_HALTED: begin
                // Leaving HALTED at the breakpoint PC lets that instruction execute once.
                if (i_step_req) begin
                    state_nxt = ST_STEP;
                    mask_nxt  = pc_match;
                end else if (i_run_req) begin
                    state_nxt = ST_RUN;
                    mask_nxt  = pc_match;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
        if ((state_nxt == ST_HALTED) && (state != ST_HALTED)) begin
            mask_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_BOOT;
            cause       <= CAUSE_NONE;
            hold_cnt    <= '0;
            resume_mask <= 1'b0;
            step_done   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cause       <= cause_nxt;
            hold_cnt    <= hold_nxt;
            resume_mask <= mask_nxt;
            step_done   <= in_step;
        end
    end

    ctrl_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (state != ST_BOOT),
        .i_clr   (i_cnt_clr),
        .o_cnt   (o_cycle_cnt)
    );

    ctrl_counter #(.CNT_W(CNT_W)) u_insn_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (o_core_en),
        .i_clr   (i_cnt_clr),
        .o_cnt   (o_insn_cnt)
    );

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the run/halt/step rules.
module tb_core_run_ctrl;

    localparam int unsigned BOOT_HOLD = 4;
    localparam int unsigned CNT_W     = 32;
    localparam int S_BOOT = 0, S_RUN = 1, S_STEP = 2, S_HALTED = 3;
    localparam int C_NONE = 0, C_REQ = 1, C_BREAK = 2, C_STEP = 3, C_ILLEGAL = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             run_req, halt_req, step_req, bp_en, vld, cnt_clr;
    logic [31:0]      bp_addr, pc;
    logic             core_en, halted, step_done;
    logic [1:0]       state;
    logic [2:0]       cause;
    logic [CNT_W-1:0] cycle_cnt, insn_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int          m_state, m_hold, m_cause;
    bit          m_step_done, m_mask;
    logic [31:0] m_cyc, m_insn;

    always #5 clk = ~clk;

    core_run_ctrl #(.BOOT_HOLD(BOOT_HOLD), .AUTORUN(1'b1), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_run_req    (run_req),
        .i_halt_req   (halt_req),
        .i_step_req   (step_req),
        .i_bp_en      (bp_en),
        .i_bp_addr    (bp_addr),
        .i_pc         (pc),
        .i_insn_vld   (vld),
        .i_cnt_clr    (cnt_clr),
        .o_core_en    (core_en),
        .o_halted     (halted),
        .o_state      (state),
        .o_halt_cause (cause),
        .o_step_done  (step_done),
        .o_cycle_cnt  (cycle_cnt),
        .o_insn_cnt   (insn_cnt)
    );

    function automatic bit m_bp();
        return bp_en && (pc == bp_addr) && !m_mask;
    endfunction

    function automatic bit m_en();
        return (m_state == S_RUN || m_state == S_STEP) && vld && !m_bp()
               && !(m_state == S_RUN && halt_req);
    endfunction

    task automatic model_reset();
        m_state = S_BOOT; m_hold = 0; m_cause = C_NONE;
        m_step_done = 1'b0; m_mask = 1'b0; m_cyc = '0; m_insn = '0;
    endtask

    task automatic model_step();
        bit bp, en, nmask;
        int ns, nc;
        bp = m_bp(); en = m_en();
        ns = m_state; nc = m_cause; nmask = m_mask && !en;
        if (m_state == S_BOOT) begin
            m_hold = m_hold + 1;
            if (m_hold == BOOT_HOLD) begin ns = S_RUN; m_hold = 0; end
        end else if (m_state == S_RUN) begin
            if (halt_req)  begin ns = S_HALTED; nc = C_REQ; end
            else if (bp)   begin ns = S_HALTED; nc = C_BREAK; end
            else if (!vld) begin ns = S_HALTED; nc = C_ILLEGAL; end
        end else if (m_state == S_STEP) begin
            ns = S_HALTED;
            nc = bp ? C_BREAK : (!vld ? C_ILLEGAL : C_STEP);
        end else begin
            if (step_req)     begin ns = S_STEP; nmask = (pc == bp_addr); end
            else if (run_req) begin ns = S_RUN;  nmask = (pc == bp_addr); end
        end
        if (ns == S_HALTED && m_state != S_HALTED) nmask = 1'b0;
        m_cyc  = cnt_clr ? 32'd0 : m_cyc  + ((m_state != S_BOOT) ? 32'd1 : 32'd0);
        m_insn = cnt_clr ? 32'd0 : m_insn + (en ? 32'd1 : 32'd0);
        m_step_done = (m_state == S_STEP);
        m_state = ns; m_cause = nc; m_mask = nmask;
    endtask

    task automatic clk_step();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic clear_inputs();
        run_req = 0; halt_req = 0; step_req = 0; bp_en = 0;
        bp_addr = '0; pc = '0; vld = 1; cnt_clr = 0;
    endtask

    task automatic do_boot();
        rst = 1; clear_inputs(); model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (BOOT_HOLD) clk_step();
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 rst = 1; model_reset();
        #1;
        checks++; if (state !== 2'd0 || core_en !== 1'b0 || cause !== 3'd0 || step_done !== 1'b0) begin
            errors++; $display("FAIL reset_state: state=%0d core_en=%b cause=%0d step_done=%b want 0/0/0/0", state, core_en, cause, step_done); end
        checks++; if (cycle_cnt !== 32'd0 || insn_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: cyc=%0d insn=%0d want 0/0", cycle_cnt, insn_cnt); end
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < int'(BOOT_HOLD); i++) begin
            #1;
            checks++; if (core_en !== 1'b0 || state !== 2'd0) begin
                errors++; $display("FAIL boot_hold[%0d]: core_en=%b state=%0d want 0/0", i, core_en, state); end
            clk_step();
        end
        #1;
        checks++; if (state !== 2'd1 || core_en !== 1'b1) begin
            errors++; $display("FAIL boot_exit: state=%0d core_en=%b want 1/1", state, core_en); end
        clk_step();
        checks++; if (cycle_cnt !== 32'd1) begin
            errors++; $display("FAIL first_cycle_cnt: got %0d want 1", cycle_cnt); end
    endtask

    task automatic test_breakpoint();
        logic [31:0] halt_pc;
        do_boot();
        bp_en = 1; bp_addr = 32'h10; halt_pc = 32'hffff_ffff;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!core_en) begin halt_pc = pc; break; end
            clk_step(); pc = pc + 32'd4;
        end
        checks++; if (halt_pc !== 32'h10 || insn_cnt !== 32'd4) begin
            errors++; $display("FAIL bp_stop: pc=%h insn=%0d want 10/4", halt_pc, insn_cnt); end
        clk_step();
        checks++; if (halted !== 1'b1 || cause !== 3'(C_BREAK)) begin
            errors++; $display("FAIL bp_cause: halted=%b cause=%0d want 1/%0d", halted, cause, C_BREAK); end
        run_req = 1; clk_step(); run_req = 0; #1;
        checks++; if (state !== 2'd1 || core_en !== 1'b1) begin
            errors++; $display("FAIL bp_resume: state=%0d core_en=%b want 1/1", state, core_en); end
        clk_step(); pc = 32'h14; #1;
        checks++; if (state !== 2'd1 || core_en !== 1'b1) begin
            errors++; $display("FAIL bp_past: state=%0d core_en=%b want 1/1", state, core_en); end
        clk_step(); pc = 32'h10; #1;
        checks++; if (core_en !== 1'b0) begin
            errors++; $display("FAIL bp_rehit: core_en=%b want 0", core_en); end
        clk_step();
        checks++; if (halted !== 1'b1 || cause !== 3'(C_BREAK) || insn_cnt !== 32'd6) begin
            errors++; $display("FAIL bp_rehalt: halted=%b cause=%0d insn=%0d want 1/%0d/6", halted, cause, insn_cnt, C_BREAK); end
    endtask

    task automatic test_step_priority();
        step_req = 1; run_req = 1; clk_step(); step_req = 0; run_req = 0; #1;
        checks++; if (state !== 2'd2 || core_en !== 1'b1) begin
            errors++; $display("FAIL step_enter: state=%0d core_en=%b want 2/1", state, core_en); end
        clk_step();
        checks++; if (state !== 2'd3 || cause !== 3'(C_STEP) || step_done !== 1'b1 || insn_cnt !== 32'd7) begin
            errors++; $display("FAIL step_done: state=%0d cause=%0d done=%b insn=%0d want 3/%0d/1/7", state, cause, step_done, insn_cnt, C_STEP); end
        clk_step();
        checks++; if (step_done !== 1'b0 || state !== 2'd3) begin
            errors++; $display("FAIL step_pulse: done=%b state=%0d want 0/3", step_done, state); end
    endtask

    task automatic test_illegal();
        pc = 32'h20; run_req = 1; clk_step(); run_req = 0; vld = 0; #1;
        checks++; if (core_en !== 1'b0) begin
            errors++; $display("FAIL ill_block: core_en=%b want 0", core_en); end
        clk_step();
        checks++; if (halted !== 1'b1 || cause !== 3'(C_ILLEGAL) || insn_cnt !== 32'd7) begin
            errors++; $display("FAIL ill_halt: halted=%b cause=%0d insn=%0d want 1/%0d/7", halted, cause, insn_cnt, C_ILLEGAL); end
        halt_req = 1; clk_step(); halt_req = 0;
        checks++; if (state !== 2'd3 || cause !== 3'(C_ILLEGAL)) begin
            errors++; $display("FAIL halt_ignored: state=%0d cause=%0d want 3/%0d", state, cause, C_ILLEGAL); end
    endtask

    task automatic test_cnt_clr_reset();
        vld = 1; run_req = 1; clk_step(); run_req = 0; #1;
        checks++; if (core_en !== 1'b1) begin
            errors++; $display("FAIL clr_commit: core_en=%b want 1", core_en); end
        cnt_clr = 1; clk_step(); cnt_clr = 0;
        checks++; if (cycle_cnt !== 32'd0 || insn_cnt !== 32'd0) begin
            errors++; $display("FAIL cnt_clr: cyc=%0d insn=%0d want 0/0", cycle_cnt, insn_cnt); end
        #2 rst = 1; model_reset(); #1;
        checks++; if (state !== 2'd0 || core_en !== 1'b0) begin
            errors++; $display("FAIL async_reset: state=%0d core_en=%b want 0/0", state, core_en); end
    endtask

    task automatic test_random();
        do_boot();
        bp_addr = 32'h40;
        for (int i = 0; i < 400; i++) begin
            run_req  = ($urandom % 6) == 0;
            halt_req = ($urandom % 12) == 0;
            step_req = ($urandom % 7) == 0;
            bp_en    = ($urandom % 2) == 0;
            pc       = 32'h3c + 32'd4 * ($urandom % 3);
            vld      = ($urandom % 10) != 0;
            cnt_clr  = ($urandom % 40) == 0;
            #1;
            checks++; if (core_en !== m_en()) begin
                errors++; $display("FAIL rnd_core_en[%0d]: got %b want %b", i, core_en, m_en()); end
            checks++; if (state !== 2'(m_state) || halted !== (m_state == S_HALTED)) begin
                errors++; $display("FAIL rnd_state[%0d]: got %0d/%b want %0d", i, state, halted, m_state); end
            checks++; if (cause !== 3'(m_cause) || step_done !== m_step_done) begin
                errors++; $display("FAIL rnd_cause[%0d]: cause=%0d done=%b want %0d/%b", i, cause, step_done, m_cause, m_step_done); end
            checks++; if (cycle_cnt !== m_cyc || insn_cnt !== m_insn) begin
                errors++; $display("FAIL rnd_cnt[%0d]: cyc=%0d insn=%0d want %0d/%0d", i, cycle_cnt, insn_cnt, m_cyc, m_insn); end
            clk_step();
        end
    endtask

    initial begin
        rst = 1; clear_inputs(); model_reset();
        test_reset();
        test_breakpoint();
        test_step_priority();
        test_illegal();
        test_cnt_clr_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
        $fatal(1);
    end

endmodule
